pl_tx_scheduler: RTL and testbench
==================================

# pl_tx_scheduler

Transmit-side packet scheduler for the Gen1/Gen2 physical layer. It arbitrates between the DLL's TLP source and DLLP source, and owns the 512-bit, 64-byte transmit beat. It inserts 8b/10b framing K-symbols (STP, SDP, END, PAD) and the per-byte DK mask, producing exactly the beat format that packet_identifier parses on the receive side. It sits between the data-link layer and the lane striping/encoder stage and keeps TLPs atomic on the link.

## Interface
Parameters:
- STARVE_MAX, 4: maximum consecutive DLLP grants while a TLP is waiting before the TLP must win.
- PAD_SYM, 8'hF7: PAD K-symbol. STP = 8'hFB, SDP = 8'h5C and END = 8'hFD are fixed.

Ports (clock and reset are one clock, asynchronous active-low reset):
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- linkup, input, 1: link trained; when low, transmission is disabled.
- gen, input, 3: 3'b000 = Gen1 and 3'b001 = Gen2 are supported; any other value disables the block.
- tlp_valid, input, 1: TLP beat offered.
- tlp_ready, output, 1: TLP beat accepted this cycle when high together with tlp_valid.
- tlp_data, input, 512: TLP payload; byte i at [8i+7:8i].
- tlp_bytes, input, 7: valid payload bytes in the beat, packed from byte 0; clamped to the range 1..62.
- tlp_last, input, 1: final beat of the TLP.
- dllp_valid, input, 1: DLLP offered.
- dllp_ready, output, 1: DLLP accepted.
- dllp_data, input, 48: 6-byte DLLP; byte 0 at [7:0].
- out_ready, input, 1: downstream accepts data_out.
- data_out, output, 512: framed beat.
- dk_out, output, 64: bit i = 1 means byte i is a K-symbol.
- valid_out, output, 1: data_out/dk_out are valid.

## Operation
State machine:
- IDLE: at a packet boundary.
  - dllp_valid only: grant the DLLP.
  - tlp_valid only: grant the TLP and go to TLP.
  - Both valid: the DLLP wins unless starve_cnt == STARVE_MAX, in which case the TLP wins.
  - A TLP beat with tlp_last = 1 taken in IDLE leaves the state in IDLE.
- TLP: mid-packet. dllp_ready = 0 and only TLP beats are accepted. The beat with tlp_last returns the state to IDLE.

starve_cnt (width clog2(STARVE_MAX+1)):
- Increments by 1 on each DLLP grant in IDLE while tlp_valid = 1.
- Saturates at STARVE_MAX.
- Clears on a TLP grant, or in any IDLE cycle with tlp_valid = 0.

Beat construction (registered):
- DLLP beat: byte0 = SDP, bytes 1..6 = dllp_data, byte7 = END, bytes 8..63 = PAD. dk_out = 64'hFFFF_FFFF_FFFF_FF81.
- TLP beat, payload length n after clamping:
  - On the first beat, byte0 = STP and the payload occupies bytes 1..n. On later beats the payload occupies bytes 0..n-1.
  - If tlp_last, END follows the payload immediately.
  - All remaining bytes are PAD.
  - DK = 1 for STP, END and PAD bytes; DK = 0 for payload bytes.
- Non-first beats may carry up to 62 bytes. The scheduler does not split or shift data across beats.

Enable condition:
- en = linkup && (gen == 0 || gen == 1).
- While en = 0: tlp_ready = dllp_ready = 0, and the state is forced to IDLE.
- If en falls mid-TLP, the packet is abandoned: state goes to IDLE and no END is emitted.
- The output register is cleared on the cycle after en falls.
- starve_cnt is cleared.

## Timing
- Reset values: valid_out = 0, data_out = 0, dk_out = 0, tlp_ready = 0, dllp_ready = 0, state = IDLE, starve_cnt = 0.
- Ready signals are combinational from the state, en, the arbitration decision and output-register occupancy.
  - A grant requires en and that the output register is empty, or out_ready = 1.
  - tlp_ready and dllp_ready are never high in the same cycle.
- Latency: an input accepted in cycle N appears on data_out/dk_out with valid_out = 1 in cycle N+1.
- Backpressure: while valid_out = 1 and out_ready = 0, data_out and dk_out are held stable and no new grant is issued.
- Idle: when nothing is granted and the register drains, valid_out = 0 and data_out = dk_out = 0.
- Throughput: one beat per cycle at full rate with out_ready held high.
- Reset asserted mid-packet: everything returns to reset values immediately, with no END emitted.

## Test plan
- DLLP only: dllp_data = 48'hAABBCCDDEEFF.
  - The cycle after the grant: data_out[63:0] = 64'hFD_AABBCCDDEEFF_5C.
  - Bytes 8..63 = F7.
  - dk_out = 64'hFFFF_FFFF_FFFF_FF81 and valid_out = 1.
- Single-beat TLP: tlp_data[31:0] = 32'h11223344, tlp_bytes = 4, tlp_last = 1.
  - data_out[47:0] = 48'hFD_11223344_FB.
  - The remaining bytes = F7.
  - dk_out = 64'hFFFF_FFFF_FFFF_FFE1.
- Three-beat TLP (62 / 62 / 10 bytes) with dllp_valid held high throughout:
  - dllp_ready = 0 for all three beats.
  - The last beat has END at byte 10 and dk_out = 64'hFFFF_FFFF_FFFF_FC00.
  - The DLLP is granted in the cycle after tlp_last is accepted.
- Starvation with STARVE_MAX = 4: tlp_valid and dllp_valid held high continuously.
  - Grant order: D D D D T D D D D T...
  - starve_cnt never exceeds 4.
- Backpressure: hold out_ready = 0 for 3 cycles after a DLLP beat.
  - data_out is stable and both ready signals are 0.
  - The next grant occurs only in the cycle out_ready returns to 1.
- Abort conditions:
  - linkup falls after the first beat of a 3-beat TLP: the next cycle has valid_out = 0 and state = IDLE, and no END is emitted.
  - gen = 3'b010 with linkup = 1: tlp_ready = dllp_ready = 0.
  - rst_n pulsed low mid-packet: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/pl_tx_if.sv
// Transmit scheduler bus: TLP and DLLP source channels plus the framed output beat.
// The master side is the data-link layer / downstream pair; the slave side is the scheduler.
interface pl_tx_if;
   logic         tlp_valid;
   logic         tlp_ready;
   logic [511:0] tlp_data;
   logic [6:0]   tlp_bytes;
   logic         tlp_last;
   logic         dllp_valid;
   logic         dllp_ready;
   logic [47:0]  dllp_data;
   logic         out_ready;
   logic [511:0] data_out;
   logic [63:0]  dk_out;
   logic         valid_out;

   modport master (
      output tlp_valid, tlp_data, tlp_bytes, tlp_last, dllp_valid, dllp_data, out_ready,
      input  tlp_ready, dllp_ready, data_out, dk_out, valid_out
   );

   modport slave (
      input  tlp_valid, tlp_data, tlp_bytes, tlp_last, dllp_valid, dllp_data, out_ready,
      output tlp_ready, dllp_ready, data_out, dk_out, valid_out
   );
endinterface

// File: rtl/pl_tx_scheduler.sv
// Gen1/Gen2 transmit scheduler: arbitrates TLP vs DLLP, keeps TLPs atomic and frames each
// 64-byte beat with STP/SDP/END/PAD K-symbols and a per-byte DK mask.
module pl_tx_scheduler #(
   parameter int unsigned STARVE_MAX = 4,
   parameter logic [7:0]  PAD_SYM    = 8'hF7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       linkup,
   input  logic [2:0] gen,
   pl_tx_if.slave     bus
);

   localparam int unsigned SW      = $clog2(STARVE_MAX + 1);
   localparam logic [7:0]  STP_SYM = 8'hFB;
   localparam logic [7:0]  SDP_SYM = 8'h5C;
   localparam logic [7:0]  END_SYM = 8'hFD;
   localparam logic [63:0] DLLP_DK = 64'hFFFF_FFFF_FFFF_FF81;

   typedef enum logic {StIdle, StTlp} state_e;

   state_e        state_q;
   logic [SW-1:0] starve_q;
   logic          valid_q;
   logic [511:0]  data_q;
   logic [63:0]   dk_q;

   logic          en;
   logic          can_grant;
   logic          tlp_pref;
   logic          starved;
   logic          tlp_fire;
   logic          dllp_fire;
   logic          first;
   logic [6:0]    n_bytes;
   logic [6:0]    lo;
   logic [6:0]    hi;
   logic [511:0]  shifted;
   logic [511:0]  tlp_beat;
   logic [63:0]   tlp_dk;
   logic [511:0]  dllp_beat;

   // Arbitration and ready generation; ready is gated by reset so it reads 0 while held.
   always_comb begin
      en        = linkup && (gen == 3'd0 || gen == 3'd1);
      can_grant = rst_n && en && (!valid_q || bus.out_ready);
      starved   = (starve_q == SW'(STARVE_MAX));
      tlp_pref  = (state_q == StTlp) || !bus.dllp_valid || starved;
      tlp_fire  = can_grant && bus.tlp_valid && tlp_pref;
      dllp_fire = can_grant && (state_q == StIdle) && bus.dllp_valid &&
                  !(bus.tlp_valid && tlp_pref);
   end

   assign bus.tlp_ready  = tlp_fire;
   assign bus.dllp_ready = dllp_fire;
   assign bus.valid_out  = valid_q;
   assign bus.data_out   = data_q;
   assign bus.dk_out     = dk_q;

   // TLP beat framing: payload lives in [lo, hi), END at hi when last, PAD elsewhere.
   always_comb begin
      first   = (state_q == StIdle);
      if (bus.tlp_bytes == 7'd0) begin
         n_bytes = 7'd1;
      end else if (bus.tlp_bytes > 7'd62) begin
         n_bytes = 7'd62;
      end else begin
         n_bytes = bus.tlp_bytes;
      end
      lo       = {6'd0, first};
      hi       = lo + n_bytes;
      shifted  = first ? {bus.tlp_data[503:0], 8'h00} : bus.tlp_data;
      tlp_beat = '0;
      tlp_dk   = '0;
      for (int i = 0; i < 64; i++) begin
         if (first && i == 0) begin
            tlp_beat[8*i +: 8] = STP_SYM;
            tlp_dk[i]          = 1'b1;
         end else if (7'(i) < hi) begin
            tlp_beat[8*i +: 8] = shifted[8*i +: 8];
            tlp_dk[i]          = 1'b0;
         end else if (bus.tlp_last && 7'(i) == hi) begin
            tlp_beat[8*i +: 8] = END_SYM;
            tlp_dk[i]          = 1'b1;
         end else begin
            tlp_beat[8*i +: 8] = PAD_SYM;
            tlp_dk[i]          = 1'b1;
         end
      end
      dllp_beat = {{56{PAD_SYM}}, END_SYM, bus.dllp_data, SDP_SYM};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         starve_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         dk_q     <= '0;
      end else if (!en) begin
         // Link down or unsupported rate: abandon any packet without END.
         state_q  <= StIdle;
         starve_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         dk_q     <= '0;
      end else if (tlp_fire) begin
         state_q  <= bus.tlp_last ? StIdle : StTlp;
         starve_q <= '0;
         valid_q  <= 1'b1;
         data_q   <= tlp_beat;
         dk_q     <= tlp_dk;
      end else if (dllp_fire) begin
         if (!bus.tlp_valid) begin
            starve_q <= '0;
         end else if (!starved) begin
            starve_q <= starve_q + 1'b1;
         end
         valid_q <= 1'b1;
         data_q  <= dllp_beat;
         dk_q    <= DLLP_DK;
      end else begin
         if (!valid_q || bus.out_ready) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dk_q    <= '0;
         end
         if (state_q == StIdle && !bus.tlp_valid) begin
            starve_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pl_tx_scheduler.sv
// Self-checking bench for pl_tx_scheduler: directed test-plan scenarios followed by random
// traffic, all checked cycle by cycle against a byte-list reference model.
module tb_pl_tx_scheduler;

   localparam int STARVE_MAX = 4;

   logic       clk;
   logic       rst_n;
   logic       linkup;
   logic [2:0] gen;

   pl_tx_if bus ();

   pl_tx_scheduler #(
      .STARVE_MAX (STARVE_MAX),
      .PAD_SYM    (8'hF7)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .linkup (linkup),
      .gen    (gen),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic         m_valid;
   logic [511:0] m_data;
   logic [63:0]  m_dk;
   bit           m_in_tlp;
   int           m_starve;
   bit           seen_tr;
   bit           seen_dr;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_data   = '0;
      m_dk     = '0;
      m_in_tlp = 1'b0;
      m_starve = 0;
   endtask

   task automatic pack(input byte unsigned q[$], input bit kq[$],
                       output logic [511:0] d, output logic [63:0] k);
      for (int i = 0; i < 64; i++) begin
         d[8*i +: 8] = q[i];
         k[i]        = kq[i];
      end
   endtask

   task automatic build_tlp(input logic [511:0] pay, input logic [6:0] nb, input bit first,
                            input bit last, output logic [511:0] d, output logic [63:0] k);
      byte unsigned q[$];
      bit           kq[$];
      int           n;
      n = (nb < 1) ? 1 : (nb > 62) ? 62 : int'(nb);
      if (first) begin
         q.push_back(8'hFB);
         kq.push_back(1'b1);
      end
      for (int j = 0; j < n; j++) begin
         q.push_back(pay[8*j +: 8]);
         kq.push_back(1'b0);
      end
      if (last) begin
         q.push_back(8'hFD);
         kq.push_back(1'b1);
      end
      while (q.size() < 64) begin
         q.push_back(8'hF7);
         kq.push_back(1'b1);
      end
      pack(q, kq, d, k);
   endtask

   task automatic build_dllp(input logic [47:0] p, output logic [511:0] d,
                             output logic [63:0] k);
      byte unsigned q[$];
      bit           kq[$];
      q.push_back(8'h5C);
      kq.push_back(1'b1);
      for (int j = 0; j < 6; j++) begin
         q.push_back(p[8*j +: 8]);
         kq.push_back(1'b0);
      end
      q.push_back(8'hFD);
      kq.push_back(1'b1);
      while (q.size() < 64) begin
         q.push_back(8'hF7);
         kq.push_back(1'b1);
      end
      pack(q, kq, d, k);
   endtask

   // One clock: at the falling edge compare outputs/readies with the model, then advance it.
   task automatic tick();
      bit  en;
      bit  can;
      byte winner;
      @(negedge clk);
      en = linkup && (gen < 3'd2);
      check("valid_out", bus.valid_out, m_valid);
      check("data_out", bus.data_out, m_data);
      check("dk_out", bus.dk_out, m_dk);
      can = en && (!m_valid || bus.out_ready);
      winner = "N";
      if (can) begin
         if (m_in_tlp) begin
            if (bus.tlp_valid) winner = "T";
         end else if (bus.tlp_valid && bus.dllp_valid) begin
            winner = (m_starve >= STARVE_MAX) ? "T" : "D";
         end else if (bus.tlp_valid) begin
            winner = "T";
         end else if (bus.dllp_valid) begin
            winner = "D";
         end
      end
      check("tlp_ready", bus.tlp_ready, winner == "T");
      check("dllp_ready", bus.dllp_ready, winner == "D");
      seen_tr = bus.tlp_ready;
      seen_dr = bus.dllp_ready;
      if (!en) begin
         model_reset();
      end else if (winner == "T") begin
         build_tlp(bus.tlp_data, bus.tlp_bytes, !m_in_tlp, bus.tlp_last, m_data, m_dk);
         m_valid  = 1'b1;
         m_in_tlp = !bus.tlp_last;
         m_starve = 0;
      end else if (winner == "D") begin
         build_dllp(bus.dllp_data, m_data, m_dk);
         m_valid  = 1'b1;
         m_starve = bus.tlp_valid ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1)
                                  : 0;
      end else begin
         if (!m_valid || bus.out_ready) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_dk    = '0;
         end
         if (!m_in_tlp && !bus.tlp_valid) m_starve = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.tlp_valid  = 1'b0;
      bus.tlp_data   = '0;
      bus.tlp_bytes  = 7'd1;
      bus.tlp_last   = 1'b0;
      bus.dllp_valid = 1'b0;
      bus.dllp_data  = '0;
      bus.out_ready  = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, bus.valid_out, 1'b0);
      check({tag, "_data"}, bus.data_out, '0);
      check({tag, "_dk"}, bus.dk_out, '0);
      check({tag, "_tlp_ready"}, bus.tlp_ready, 1'b0);
      check({tag, "_dllp_ready"}, bus.dllp_ready, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [511:0] saved;
      logic [9:0]   order;
      int           n_d;
      bit           got_t;

      // Reset state, with requests pending to show ready stays low during reset
      rst_n  = 1'b0;
      linkup = 1'b1;
      gen    = 3'd0;
      idle_inputs();
      bus.dllp_valid = 1'b1;
      bus.tlp_valid  = 1'b1;
      model_reset();
      #3;
      check_all_zero("reset");
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // DLLP only
      bus.dllp_valid = 1'b1;
      bus.dllp_data  = 48'hAABBCCDDEEFF;
      tick();
      bus.dllp_valid = 1'b0;
      check("dllp_lo", bus.data_out[63:0], 64'hFDAABBCCDDEEFF5C);
      check("dllp_pad", bus.data_out[511:64], {56{8'hF7}});
      check("dllp_dk", bus.dk_out, 64'hFFFF_FFFF_FFFF_FF81);
      check("dllp_valid", bus.valid_out, 1'b1);
      tick();

      // Single-beat TLP
      bus.tlp_valid        = 1'b1;
      bus.tlp_data         = '0;
      bus.tlp_data[31:0]   = 32'h11223344;
      bus.tlp_bytes        = 7'd4;
      bus.tlp_last         = 1'b1;
      tick();
      bus.tlp_valid = 1'b0;
      check("tlp1_lo", bus.data_out[47:0], 48'hFD11223344FB);
      check("tlp1_pad", bus.data_out[511:48], {58{8'hF7}});
      check("tlp1_dk", bus.dk_out, 64'hFFFF_FFFF_FFFF_FFE1);
      tick();

      // Three-beat TLP with a DLLP competing throughout; TLP wins once starved
      bus.dllp_valid = 1'b1;
      bus.dllp_data  = 48'h010203040506;
      bus.tlp_valid  = 1'b1;
      bus.tlp_bytes  = 7'd62;
      bus.tlp_last   = 1'b0;
      for (int k = 0; k < 16; k++) bus.tlp_data[32*k +: 32] = $urandom;
      n_d   = 0;
      got_t = 1'b0;
      for (int c = 0; c < 10 && !got_t; c++) begin
         tick();
         if (seen_tr) got_t = 1'b1;
         else if (seen_dr) n_d++;
      end
      check("tlp3_granted", got_t, 1'b1);
      check("tlp3_dllps_before", n_d, STARVE_MAX);
      tick();
      check("tlp3_b2_dllp_ready", seen_dr, 1'b0);
      check("tlp3_b2_tlp_ready", seen_tr, 1'b1);
      bus.tlp_bytes = 7'd10;
      bus.tlp_last  = 1'b1;
      tick();
      check("tlp3_b3_dllp_ready", seen_dr, 1'b0);
      check("tlp3_b3_end", bus.data_out[87:80], 8'hFD);
      check("tlp3_b3_dk", bus.dk_out, 64'hFFFF_FFFF_FFFF_FC00);
      bus.tlp_valid = 1'b0;
      tick();
      check("tlp3_dllp_after", seen_dr, 1'b1);

      // Starvation: both sources held, single-beat TLPs
      bus.tlp_valid = 1'b1;
      bus.tlp_bytes = 7'd8;
      bus.tlp_last  = 1'b1;
      order = '0;
      for (int g = 0; g < 10; g++) begin
         tick();
         order[g] = seen_tr;
      end
      check("starve_order", order, 10'h210);
      idle_inputs();
      tick();

      // Backpressure after a DLLP beat
      bus.dllp_valid = 1'b1;
      bus.dllp_data  = 48'h123456789ABC;
      tick();
      saved          = bus.data_out;
      bus.out_ready  = 1'b0;
      bus.dllp_data  = 48'hFEDCBA987654;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp_hold", bus.data_out, saved);
         check("bp_no_grant", {seen_tr, seen_dr}, 2'b00);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_regrant", seen_dr, 1'b1);
      idle_inputs();
      tick();

      // Link drops after the first beat of a multi-beat TLP
      bus.tlp_valid = 1'b1;
      bus.tlp_bytes = 7'd62;
      bus.tlp_last  = 1'b0;
      tick();
      linkup = 1'b0;
      tick();
      check("abort_no_ready", seen_tr, 1'b0);
      check("abort_valid", bus.valid_out, 1'b0);
      linkup         = 1'b1;
      bus.tlp_valid  = 1'b0;
      bus.dllp_valid = 1'b1;
      tick();
      check("abort_idle_dllp", seen_dr, 1'b1);
      bus.dllp_valid = 1'b0;
      bus.tlp_valid  = 1'b1;
      bus.tlp_last   = 1'b1;
      bus.tlp_bytes  = 7'd3;
      tick();
      check("abort_new_stp", bus.data_out[7:0], 8'hFB);
      idle_inputs();
      tick();

      // Unsupported rate
      gen            = 3'b010;
      bus.tlp_valid  = 1'b1;
      bus.dllp_valid = 1'b1;
      tick();
      check("gen2_no_ready", {seen_tr, seen_dr}, 2'b00);
      gen = 3'd1;
      idle_inputs();
      tick();

      // Reset pulse mid-packet
      bus.tlp_valid = 1'b1;
      bus.tlp_bytes = 7'd20;
      bus.tlp_last  = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      bus.tlp_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         bus.tlp_valid  = ($urandom % 4) != 0;
         bus.dllp_valid = ($urandom % 3) == 0;
         bus.tlp_bytes  = 7'($urandom % 128);
         bus.tlp_last   = ($urandom % 4) == 0;
         for (int k = 0; k < 16; k++) bus.tlp_data[32*k +: 32] = $urandom;
         bus.dllp_data  = {16'($urandom), 32'($urandom)};
         bus.out_ready  = ($urandom % 5) != 0;
         linkup         = ($urandom % 64) != 0;
         gen            = (($urandom % 32) == 0) ? 3'($urandom % 8) : 3'($urandom % 2);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
